// File: rtl/pipelined_alu.sv
// Pipelined ALU with valid/ready flow control and an architectural NZVC flag register.
// The operation is evaluated combinationally ahead of stage 1. Later stages only carry it forward.
module pipelined_alu #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       cntrl,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic [3:0]       flags_q
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_LSL  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_LSR  = 3'b111;

  logic             stall;
  logic             sub_p0;
  logic [WIDTH-1:0] b_eff_p0;
  logic [WIDTH:0]   sum_p0;
  logic [SHW-1:0]   shamt_p0;
  logic [WIDTH-1:0] res_p0;
  logic             v_p0;
  logic             c_p0;
  logic [3:0]       flags_p0;

  logic [STAGES-1:0] vld_p;
  logic [STAGES-1:0] sf_p;
  logic [WIDTH-1:0]  res_p [STAGES];
  logic [3:0]        flg_p [STAGES];

  // ---- stage 0: combinational compute ----
  always_comb begin
    // Subtraction reuses the adder as A + ~B + 1, so carry out means "no borrow".
    sub_p0   = (cntrl == OP_SUB);
    b_eff_p0 = sub_p0 ? ~B : B;
    sum_p0   = {1'b0, A} + {1'b0, b_eff_p0} + {{WIDTH{1'b0}}, sub_p0};
    shamt_p0 = B[SHW-1:0];
    res_p0   = B;
    v_p0     = 1'b0;
    c_p0     = 1'b0;
    case (cntrl)
      OP_PASS: res_p0 = B;
      OP_LSL:  res_p0 = A << shamt_p0;
      OP_ADD, OP_SUB: begin
        res_p0 = sum_p0[WIDTH-1:0];
        c_p0   = sum_p0[WIDTH];
        // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
        v_p0   = (sum_p0[WIDTH-1] ^ A[WIDTH-1] ^ b_eff_p0[WIDTH-1]) ^ sum_p0[WIDTH];
      end
      OP_AND:  res_p0 = A & B;
      OP_OR:   res_p0 = A | B;
      OP_XOR:  res_p0 = A ^ B;
      OP_LSR:  res_p0 = A >> shamt_p0;
      default: res_p0 = B;
    endcase
  end

  assign flags_p0 = {res_p0[WIDTH-1], (res_p0 == '0), v_p0, c_p0};

  assign out_valid = vld_p[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;

  // ---- stages 1..STAGES: valid chain, frozen as a whole while stalled ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p <= '0;
    end else if (!stall) begin
      vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      res_p[0] <= res_p0;
      flg_p[0] <= flags_p0;
      sf_p[0]  <= set_flags;
      for (int k = 1; k < STAGES; k++) begin
        res_p[k] <= res_p[k-1];
        flg_p[k] <= flg_p[k-1];
        sf_p[k]  <= sf_p[k-1];
      end
    end
  end

  // ---- retirement: output handshake commits flags ----
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (out_valid && out_ready && sf_p[STAGES-1]) begin
      flags_q <= flg_p[STAGES-1];
    end
  end

  assign result                                   = res_p[STAGES-1];
  assign {negative, zero, overflow, carry_out}    = flg_p[STAGES-1];

endmodule

// File: doc/pipelined_alu.md
Name: pipelined_alu

Overview:
- Parametrised, pipelined successor to the single-cycle 64-bit ALU.
- Adds configurable width and pipeline depth, logical shifts, valid/ready flow control on input and output, and an architectural NZVC flag register updated only by flag-setting ops (ADDS/SUBS style).
- Sits between the EX-stage operand muxes and the EX/MEM register. Multi-stage configurations support timing closure at wider WIDTH.

Parameters:
- WIDTH, 64, operand/result width in bits; must be at least 8 and a power of two.
- STAGES, 2, number of register stages from accepted input to output; must be at least 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and op are presented.
- in_ready  output  1  block can accept an op this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; also the shift amount.
- cntrl  input  3  operation select.
- set_flags  input  1  commit NZVC to the flag register when this op retires.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  operation result.
- negative  output  1  result[WIDTH-1].
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (add/sub only).
- carry_out  output  1  carry out of bit WIDTH-1 (add/sub only).
- flags_q  output  4  committed {N,Z,V,C}.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: on a clk edge with reset=1, all stage valid bits clear, out_valid=0, flags_q=4'b0000. Data registers are don't-care. in_ready=1 in the cycle after reset. Reset mid-operation discards all in-flight ops with no flag commit.
- cntrl encoding:
  - 000: result = B.
  - 001: result = A << B[log2(WIDTH)-1:0] (logical).
  - 010: result = A + B.
  - 011: result = A - B, computed as A + ~B + 1.
  - 100: result = A & B.
  - 101: result = A | B.
  - 110: result = A ^ B.
  - 111: result = A >> B[log2(WIDTH)-1:0] (logical).
- Flags:
  - negative and zero are valid for every op.
  - Add: carry_out is the unsigned carry from bit WIDTH-1.
  - Sub: carry_out = 1 means no borrow (A >= B unsigned).
  - Add/sub: overflow = carry into MSB XOR carry out of MSB.
  - All other ops drive overflow=0 and carry_out=0.
  - Shift amounts are taken modulo WIDTH; upper bits of B are ignored.
- Pipeline:
  - Computation is combinational ahead of stage 1. Stages 2..STAGES pass result, flags and set_flags unchanged.
  - Each stage holds a valid bit.
  - Latency is exactly STAGES cycles from the input handshake (in_valid and in_ready) to out_valid, when the pipeline is not stalled.
  - Stall = out_valid and not out_ready. While stalled, all stages hold, including bubbles; nothing is overwritten.
  - in_ready = not stall (combinational from out_ready and out_valid).
  - Bubbles (in_valid=0 while accepted) propagate as valid=0.
  - Full throughput: one op per cycle while out_ready=1.
- Output:
  - result and the four flags are stable while out_valid=1 and out_ready=0.
  - An output handshake (out_valid and out_ready) retires the op.
- Flag register:
  - On retirement of an op with set_flags=1, flags_q <= {negative, zero, overflow, carry_out} on that clk edge.
  - Ops with set_flags=0 never modify flags_q.
  - flags_q is visible the cycle after retirement.
- Simultaneous events:
  - reset overrides handshakes in the same cycle.
  - Input accept and output retire in the same cycle are both legal and are the steady-state case.
- Order is strictly in-order, with no reordering or dropping.

Test Plan:
- Reset then ADD, A=1, B=1, set_flags=1, out_ready=1 -> out_valid two cycles after accept; result=2, NZVC=0000; flags_q=0000 the cycle after retire.
- ADD back-to-back over consecutive cycles, with set_flags=1 only on the third op:
  - op1: A=0x4000000000000000, B=0x4000000000000000 -> result 0x8000000000000000, N=1, V=1, C=0, Z=0.
  - op2: A=0x8000000000000000, B=0x8000000000000000 -> result 0, Z=1, V=1, C=1.
  - op3: A=-1, B=1 -> result 0, Z=1, C=1, V=0.
  - Required: results in order on three consecutive cycles; flags_q=4'b0101 after op3 only.
- SUB, A=1, B=2, set_flags=1 -> result 0xFFFFFFFFFFFFFFFF, N=1, C=0, V=0; flags_q=1000. Then SUB, A=2, B=1, set_flags=0 -> result 1, C=1; flags_q stays 1000.
- Shifts:
  - LSL, A=1, B=63 -> 0x8000000000000000, N=1.
  - LSL, A=1, B=64 -> 1 (modulo).
  - LSR, A=0x8000000000000000, B=4 -> 0x0800000000000000.
  - All three: V=0, C=0.
- Backpressure: issue 4 ops with out_ready=0 -> in_ready falls once out_valid=1; hold out_ready=0 for 5 cycles and result stays constant; release -> all 4 ops emerge in order, none lost or duplicated.
- Reset mid-stream: 2 in-flight ops with set_flags=1, assert reset for 1 cycle -> out_valid=0 next cycle, flags_q=0000, and neither op ever appears on the output.
